// File: rtl/bist_tpg_lfsr.sv
// BIST test pattern generator: a seeded LFSR drives {A,B,Cin} vectors into the
// full adder under test and strobes the MISR (clear at session start, enable per vector).
module bist_tpg_lfsr #(
  parameter int               WIDTH        = 3,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(3'b110),
  parameter logic [WIDTH-1:0] SEED         = WIDTH'(3'b001),
  parameter int               NUM_PATTERNS = 8,
  parameter bit               DE_BRUIJN    = 1'b1,
  localparam int              CW           = $clog2(NUM_PATTERNS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] pattern_out,
  output logic             pattern_valid,
  output logic             ora_en,
  output logic             ora_clr,
  output logic [CW-1:0]    pattern_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pending_q, pending_d;
  logic             valid_q, valid_d;
  logic             clr_q, clr_d;
  logic             done_q, done_d;

  // The DE_BRUIJN term splices the all-zero state into the maximal-length cycle.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    logic fb;
    fb = ^(v & TAPS);
    if (DE_BRUIJN) fb = fb ^ (v[WIDTH-2:0] == '0);
    return {v[WIDTH-2:0], fb};
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      seed_q    <= SEED;
      lfsr_q    <= SEED;
      out_q     <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      lfsr_q    <= lfsr_d;
      out_q     <= out_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      clr_q     <= clr_d;
      done_q    <= done_d;
    end
  end

  // pending marks a vector advanced under hold that has not been presented yet;
  // a RUN cycle with neither valid nor pending means the last vector went out under hold.
  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    lfsr_d    = lfsr_q;
    count_d   = count_q;
    pending_d = pending_q;
    valid_d   = 1'b0;
    clr_d     = 1'b0;
    done_d    = done_q;

    if (state_q != RUN && seed_load) begin
      seed_d = (!DE_BRUIJN && seed_in == '0) ? SEED : seed_in;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          lfsr_d    = seed_d;
          count_d   = '0;
          pending_d = 1'b0;
          valid_d   = 1'b1;
          clr_d     = 1'b1;
          done_d    = 1'b0;
        end
      end
      RUN: begin
        if (valid_q) begin
          if (count_q == LAST) begin
            if (!hold) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            lfsr_d  = lfsr_step(lfsr_q);
            count_d = count_q + CW'(1);
            if (hold) pending_d = 1'b1;
            else      valid_d   = 1'b1;
          end
        end else if (!hold) begin
          if (pending_q) begin
            valid_d   = 1'b1;
            pending_d = 1'b0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    out_d = valid_d ? lfsr_d : '0;
  end

  assign pattern_out   = out_q;
  assign pattern_valid = valid_q;
  assign ora_en        = valid_q;
  assign ora_clr       = clr_q;
  assign pattern_count = count_q;
  assign busy          = (state_q == RUN);
  assign done          = done_q;

endmodule
